// File: rtl/channelif_n.sv
// Routes platform ingress to one of NUM_CH channels and one channel back to egress, locking the port address per frame.
// Latency: zero, fully combinational datapath; FSM state and drop counter update on the accepting edge.
// Backpressure: ready flows from the selected channel/platform; invalid ingress ports are dropped or stalled per DROP_INVALID.
module channelif_n #(
    parameter int NUM_CH       = 6,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int DROP_INVALID = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_sof,
    input  logic                     in_eof,
    input  logic                     in_src_rdy,
    output logic                     in_dst_rdy,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [ADDR_W-1:0]        inport_addr,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic                     out_src_rdy,
    input  logic                     out_dst_rdy,
    output logic [DATA_W-1:0]        out_data,
    input  logic [ADDR_W-1:0]        outport_addr,
    output logic [NUM_CH-1:0]        ch_out_sof,
    output logic [NUM_CH-1:0]        ch_out_eof,
    output logic [NUM_CH-1:0]        ch_out_src_rdy,
    input  logic [NUM_CH-1:0]        ch_out_dst_rdy,
    output logic [NUM_CH*DATA_W-1:0] ch_out_data,
    input  logic [NUM_CH-1:0]        ch_in_sof,
    input  logic [NUM_CH-1:0]        ch_in_eof,
    input  logic [NUM_CH-1:0]        ch_in_src_rdy,
    output logic [NUM_CH-1:0]        ch_in_dst_rdy,
    input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
    output logic [NUM_CH-1:0]        ch_wen,
    output logic [NUM_CH-1:0]        ch_ren,
    output logic [2**ADDR_W-1:0]     wenables,
    output logic [2**ADDR_W-1:0]     renables,
    output logic                     in_busy,
    output logic                     out_busy,
    output logic [15:0]              drop_cnt
);

    localparam int NPORT = 2**ADDR_W;

    typedef enum logic [1:0] {I_IDLE, I_FWD, I_DROP} in_state_t;
    typedef enum logic       {O_IDLE, O_LOCK}        out_state_t;

    in_state_t         in_state, in_state_nxt;
    out_state_t        out_state, out_state_nxt;
    logic [ADDR_W-1:0] in_addr_q, in_addr_nxt, in_eff;
    logic [ADDR_W-1:0] out_addr_q, out_addr_nxt, out_eff;
    logic              in_eff_ok, in_acc, drop_inc, out_acc;
    logic [NUM_CH-1:0] sel;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) <= NUM_CH);
    endfunction

    // Ingress routing. A start-of-frame beat always routes on the live address,
    // even inside a locked frame, so a framing error starts the new frame on its own port.
    always_comb begin
        in_eff = in_addr_q;
        if (in_state == I_IDLE || (in_state == I_FWD && in_sof))
            in_eff = inport_addr;
        in_eff_ok = addr_ok(in_eff);
        for (int k = 0; k < NUM_CH; k++)
            sel[k] = (in_state != I_DROP) && (in_eff == ADDR_W'(k + 1));
        ch_out_src_rdy = {NUM_CH{in_src_rdy}} & sel;
        ch_out_sof     = {NUM_CH{in_sof}};
        ch_out_eof     = {NUM_CH{in_eof}};
        ch_out_data    = {NUM_CH{in_data}};
        if (in_state == I_DROP)
            in_dst_rdy = 1'b1;
        else if (!in_eff_ok)
            in_dst_rdy = (DROP_INVALID != 0);
        else
            in_dst_rdy = |(sel & ch_out_dst_rdy);
        in_acc = in_src_rdy & in_dst_rdy;
    end

    // Ingress next state: sof (outside a drop) re-latches and counts a drop if the port is invalid.
    always_comb begin
        in_state_nxt = in_state;
        in_addr_nxt  = in_addr_q;
        drop_inc     = 1'b0;
        if (in_acc) begin
            if (in_sof && in_state != I_DROP) begin
                drop_inc = !in_eff_ok;
                if (in_eof) begin
                    in_state_nxt = I_IDLE;
                end else begin
                    in_addr_nxt  = inport_addr;
                    in_state_nxt = in_eff_ok ? I_FWD : I_DROP;
                end
            end else if (in_eof) begin
                in_state_nxt = I_IDLE;
            end
        end
    end

    // Egress mux: unselected or invalid ports read as idle zeros.
    always_comb begin
        out_eff       = (out_state == O_IDLE) ? outport_addr : out_addr_q;
        out_sof       = 1'b0;
        out_eof       = 1'b0;
        out_src_rdy   = 1'b0;
        out_data      = '0;
        ch_in_dst_rdy = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (out_eff == ADDR_W'(k + 1)) begin
                out_sof          = ch_in_sof[k];
                out_eof          = ch_in_eof[k];
                out_src_rdy      = ch_in_src_rdy[k];
                out_data         = ch_in_data[k*DATA_W +: DATA_W];
                ch_in_dst_rdy[k] = out_dst_rdy;
            end
        end
        out_acc = out_src_rdy & out_dst_rdy;
    end

    // Egress next state: lock on a multi-beat frame start, release on its eof.
    always_comb begin
        out_state_nxt = out_state;
        out_addr_nxt  = out_addr_q;
        if (out_acc) begin
            if (out_state == O_IDLE && out_sof && !out_eof) begin
                out_state_nxt = O_LOCK;
                out_addr_nxt  = outport_addr;
            end else if (out_state == O_LOCK && out_eof) begin
                out_state_nxt = O_IDLE;
            end
        end
    end

    // One-hot enables of the effective addresses; write enables are blanked while dropping.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            wenables[p] = (in_state != I_DROP) && (in_eff == ADDR_W'(p));
            renables[p] = (out_eff == ADDR_W'(p));
        end
        ch_wen   = wenables[NUM_CH:1];
        ch_ren   = renables[NUM_CH:1];
        in_busy  = (in_state != I_IDLE);
        out_busy = (out_state == O_LOCK);
    end

    // State registers and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state   <= I_IDLE;
            out_state  <= O_IDLE;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            drop_cnt   <= '0;
        end else begin
            in_state   <= in_state_nxt;
            out_state  <= out_state_nxt;
            in_addr_q  <= in_addr_nxt;
            out_addr_q <= out_addr_nxt;
            if (drop_inc && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_channelif_n.sv
module tb_channelif_n;

    typedef struct {
        int         ch;
        logic [7:0] dat;
        logic       sof;
        logic       eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_sof, in_eof, in_src_rdy;
    logic [7:0]  in_data;
    logic [3:0]  inport_addr, outport_addr;
    logic        out_dst_rdy;
    logic [5:0]  ch_out_dst_rdy, ch_in_sof, ch_in_eof, ch_in_src_rdy;
    logic [47:0] ch_in_data;

    logic        in_dst_rdy, out_sof, out_eof, out_src_rdy, in_busy, out_busy;
    logic [7:0]  out_data;
    logic [5:0]  ch_out_sof, ch_out_eof, ch_out_src_rdy, ch_in_dst_rdy, ch_wen, ch_ren;
    logic [47:0] ch_out_data;
    logic [15:0] wenables, renables, drop_cnt;

    logic        in_dst_rdy_b, out_sof_b, out_eof_b, out_src_rdy_b, in_busy_b, out_busy_b;
    logic [7:0]  out_data_b;
    logic [5:0]  ch_out_sof_b, ch_out_eof_b, ch_out_src_rdy_b, ch_in_dst_rdy_b, ch_wen_b, ch_ren_b;
    logic [47:0] ch_out_data_b;
    logic [15:0] wenables_b, renables_b, drop_cnt_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_drop = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    channelif_n #(.NUM_CH(6), .DATA_W(8), .ADDR_W(4), .DROP_INVALID(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_sof(in_sof), .in_eof(in_eof), .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy),
        .in_data(in_data), .inport_addr(inport_addr),
        .out_sof(out_sof), .out_eof(out_eof), .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
        .out_data(out_data), .outport_addr(outport_addr),
        .ch_out_sof(ch_out_sof), .ch_out_eof(ch_out_eof), .ch_out_src_rdy(ch_out_src_rdy),
        .ch_out_dst_rdy(ch_out_dst_rdy), .ch_out_data(ch_out_data),
        .ch_in_sof(ch_in_sof), .ch_in_eof(ch_in_eof), .ch_in_src_rdy(ch_in_src_rdy),
        .ch_in_dst_rdy(ch_in_dst_rdy), .ch_in_data(ch_in_data),
        .ch_wen(ch_wen), .ch_ren(ch_ren), .wenables(wenables), .renables(renables),
        .in_busy(in_busy), .out_busy(out_busy), .drop_cnt(drop_cnt)
    );

    // Stall variant sharing the same stimulus.
    channelif_n #(.NUM_CH(6), .DATA_W(8), .ADDR_W(4), .DROP_INVALID(0)) u_dut_stall (
        .clk(clk), .rst(rst),
        .in_sof(in_sof), .in_eof(in_eof), .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy_b),
        .in_data(in_data), .inport_addr(inport_addr),
        .out_sof(out_sof_b), .out_eof(out_eof_b), .out_src_rdy(out_src_rdy_b), .out_dst_rdy(out_dst_rdy),
        .out_data(out_data_b), .outport_addr(outport_addr),
        .ch_out_sof(ch_out_sof_b), .ch_out_eof(ch_out_eof_b), .ch_out_src_rdy(ch_out_src_rdy_b),
        .ch_out_dst_rdy(ch_out_dst_rdy), .ch_out_data(ch_out_data_b),
        .ch_in_sof(ch_in_sof), .ch_in_eof(ch_in_eof), .ch_in_src_rdy(ch_in_src_rdy),
        .ch_in_dst_rdy(ch_in_dst_rdy_b), .ch_in_data(ch_in_data),
        .ch_wen(ch_wen_b), .ch_ren(ch_ren_b), .wenables(wenables_b), .renables(renables_b),
        .in_busy(in_busy_b), .out_busy(out_busy_b), .drop_cnt(drop_cnt_b)
    );

    // Channel number whose ch_out_src_rdy is set: 0 = none, -1 = more than one.
    function automatic int obs_ch();
        if ($countones(ch_out_src_rdy) > 1) return -1;
        for (int k = 0; k < 6; k++)
            if (ch_out_src_rdy[k]) return k + 1;
        return 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++; if (in_busy !== 1'b0 || out_busy !== 1'b0)
            $display("FAIL reset_busy: got in=%b out=%b, want 0 0", in_busy, out_busy);
        n_tests++; if (drop_cnt !== 16'd0 || drop_cnt_b !== 16'd0)
            $display("FAIL reset_drop_cnt: got %h/%h, want 0000", drop_cnt, drop_cnt_b);
        n_tests++; if (ch_out_src_rdy !== 6'd0)
            $display("FAIL reset_src_rdy: got %b, want 000000", ch_out_src_rdy);
        n_tests++; if (in_dst_rdy !== 1'b1 || in_dst_rdy_b !== 1'b0)
            $display("FAIL reset_addr0_rdy: got drop=%b stall=%b, want 1 0", in_dst_rdy, in_dst_rdy_b);
        if (in_busy !== 1'b0 || out_busy !== 1'b0) n_fail++;
        if (drop_cnt !== 16'd0 || drop_cnt_b !== 16'd0) n_fail++;
        if (ch_out_src_rdy !== 6'd0) n_fail++;
        if (in_dst_rdy !== 1'b1 || in_dst_rdy_b !== 1'b0) n_fail++;
    endtask

    task automatic test_addr_lock();
        exp_t e;
        int   ch;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            in_src_rdy  = 1'b1;
            in_sof      = (b == 0);
            in_eof      = (b == 3);
            in_data     = 8'(8'h11 * (b + 1));
            inport_addr = (b == 0) ? 4'd3 : 4'd5;
            sb.push_back(exp_t'{3, in_data, in_sof, in_eof});
            @(negedge clk);
            e  = sb.pop_front();
            ch = obs_ch();
            n_tests++;
            if (in_dst_rdy !== 1'b1 || ch != e.ch || ch_out_data[(e.ch-1)*8 +: 8] !== e.dat ||
                ch_out_sof[e.ch-1] !== e.sof || ch_out_eof[e.ch-1] !== e.eof) begin
                $display("FAIL lock_beat%0d: got ch %0d rdy %b data %h, want ch %0d rdy 1 data %h",
                         b, ch, in_dst_rdy, ch_out_data[(e.ch-1)*8 +: 8], e.ch, e.dat);
                n_fail++;
            end
            n_tests++;
            if (ch_out_src_rdy[4] !== 1'b0) begin
                $display("FAIL lock_ch5_quiet beat%0d: got %b, want 0", b, ch_out_src_rdy[4]);
                n_fail++;
            end
            if (b >= 1) begin
                n_tests++;
                if (in_busy !== 1'b1 || wenables !== 16'h0008 || ch_wen !== 6'b000100) begin
                    $display("FAIL lock_busy_en beat%0d: got busy %b wen %h chwen %b, want 1 0008 000100",
                             b, in_busy, wenables, ch_wen);
                    n_fail++;
                end
            end
        end
        @(posedge clk); #1 in_src_rdy = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_busy !== 1'b0) begin
            $display("FAIL lock_release: got in_busy %b, want 0", in_busy);
            n_fail++;
        end
    endtask

    task automatic test_drop_invalid();
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            in_src_rdy  = 1'b1;
            in_sof      = (b == 0);
            in_eof      = (b == 2);
            in_data     = 8'(8'hD0 + b);
            inport_addr = 4'd9;
            @(negedge clk);
            n_tests++;
            if (in_dst_rdy !== 1'b1 || ch_out_src_rdy !== 6'd0 || in_dst_rdy_b !== 1'b0) begin
                $display("FAIL drop_beat%0d: got rdy %b srcrdy %b stall_rdy %b, want 1 000000 0",
                         b, in_dst_rdy, ch_out_src_rdy, in_dst_rdy_b);
                n_fail++;
            end
            if (b == 0) exp_drop++;
            else begin
                n_tests++;
                if (in_busy !== 1'b1 || drop_cnt !== 16'(exp_drop) || wenables !== 16'h0000) begin
                    $display("FAIL drop_state beat%0d: got busy %b cnt %0d wen %h, want 1 %0d 0000",
                             b, in_busy, drop_cnt, wenables, exp_drop);
                    n_fail++;
                end
            end
        end
        @(posedge clk); #1 in_src_rdy = 1'b0; in_sof = 1'b0; in_eof = 1'b0; inport_addr = 4'd0;
        @(negedge clk);
        n_tests++;
        if (in_busy !== 1'b0 || drop_cnt !== 16'(exp_drop) || drop_cnt_b !== 16'd0 || in_busy_b !== 1'b0) begin
            $display("FAIL drop_end: got busy %b cnt %0d stall_cnt %0d stall_busy %b, want 0 %0d 0 0",
                     in_busy, drop_cnt, drop_cnt_b, in_busy_b, exp_drop);
            n_fail++;
        end
    endtask

    task automatic test_egress_lock();
        exp_t e;
        int   b = 0;
        for (int c = 0; c < 20 && b < 5; c++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) sb.push_back(exp_t'{2, 8'(8'hA1 + b), (b == 0), (b == 4)});
            ch_in_src_rdy        = (b >= 1) ? 6'b001010 : 6'b000010;
            ch_in_sof            = {2'b00, 1'b1, 1'b0, (b == 0), 1'b0};
            ch_in_eof            = {4'b0000, (b == 4), 1'b0};
            ch_in_data[15:8]     = 8'(8'hA1 + b);
            ch_in_data[31:24]    = 8'hEE;
            outport_addr         = (b >= 1) ? 4'd4 : 4'd2;
            out_dst_rdy          = (c % 2 == 0);
            @(negedge clk);
            n_tests++;
            if (ch_in_dst_rdy !== (out_dst_rdy ? 6'b000010 : 6'b000000)) begin
                $display("FAIL egress_dst_rdy cyc%0d: got %b, want %b", c, ch_in_dst_rdy,
                         out_dst_rdy ? 6'b000010 : 6'b000000);
                n_fail++;
            end
            if (out_src_rdy && out_dst_rdy) begin
                e = sb.pop_front();
                n_tests++;
                if (out_data !== e.dat || out_sof !== e.sof || out_eof !== e.eof) begin
                    $display("FAIL egress_beat%0d: got data %h sof %b eof %b, want %h %b %b",
                             b, out_data, out_sof, out_eof, e.dat, e.sof, e.eof);
                    n_fail++;
                end
                b++;
            end
        end
        n_tests++;
        if (b != 5) begin
            $display("FAIL egress_timeout: got %0d beats, want 5", b);
            n_fail++;
        end
        @(posedge clk); #1 ch_in_src_rdy = 6'b001000; out_dst_rdy = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_busy !== 1'b0 || out_src_rdy !== 1'b1 || out_data !== 8'hEE || renables !== 16'h0010) begin
            $display("FAIL egress_release: got busy %b srcrdy %b data %h ren %h, want 0 1 ee 0010",
                     out_busy, out_src_rdy, out_data, renables);
            n_fail++;
        end
        @(posedge clk); #1 ch_in_src_rdy = 6'd0; ch_in_sof = 6'd0; ch_in_eof = 6'd0; out_dst_rdy = 1'b0;
    endtask

    task automatic test_reframe();
        exp_t e;
        int   ch;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            in_src_rdy  = 1'b1;
            in_sof      = (b == 0 || b == 2);
            in_eof      = (b == 3);
            in_data     = 8'(8'h51 + b);
            inport_addr = (b == 0) ? 4'd1 : 4'd6;
            sb.push_back(exp_t'{(b < 2) ? 1 : 6, in_data, in_sof, in_eof});
            @(negedge clk);
            e  = sb.pop_front();
            ch = obs_ch();
            n_tests++;
            if (in_dst_rdy !== 1'b1 || ch != e.ch) begin
                $display("FAIL reframe_beat%0d: got ch %0d rdy %b, want ch %0d rdy 1", b, ch, in_dst_rdy, e.ch);
                n_fail++;
            end
        end
        @(posedge clk); #1 in_src_rdy = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_busy !== 1'b0 || drop_cnt !== 16'(exp_drop)) begin
            $display("FAIL reframe_end: got busy %b cnt %0d, want 0 %0d", in_busy, drop_cnt, exp_drop);
            n_fail++;
        end
    endtask

    task automatic test_reset_midframe();
        @(posedge clk); #1;
        in_src_rdy = 1'b1; in_sof = 1'b1; in_eof = 1'b0; inport_addr = 4'd2; in_data = 8'h77;
        ch_in_src_rdy = 6'b000100; ch_in_sof = 6'b000100; ch_in_eof = 6'd0; outport_addr = 4'd3;
        out_dst_rdy = 1'b1;
        @(posedge clk); #1;
        in_src_rdy = 1'b0; in_sof = 1'b0; ch_in_src_rdy = 6'd0; ch_in_sof = 6'd0;
        inport_addr = 4'd4; outport_addr = 4'd5;
        @(negedge clk);
        n_tests++;
        if (in_busy !== 1'b1 || out_busy !== 1'b1 || drop_cnt !== 16'(exp_drop)) begin
            $display("FAIL pre_reset_lock: got busy %b/%b cnt %0d, want 1/1 %0d", in_busy, out_busy, drop_cnt, exp_drop);
            n_fail++;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; in_src_rdy = 1'b1;
        exp_drop = 0;
        @(negedge clk);
        n_tests++;
        if (in_busy !== 1'b0 || out_busy !== 1'b0 || drop_cnt !== 16'd0) begin
            $display("FAIL post_reset_state: got busy %b/%b cnt %0d, want 0/0 0", in_busy, out_busy, drop_cnt);
            n_fail++;
        end
        n_tests++;
        if (ch_out_src_rdy !== 6'b001000 || renables !== 16'h0020) begin
            $display("FAIL post_reset_live: got srcrdy %b ren %h, want 001000 0020", ch_out_src_rdy, renables);
            n_fail++;
        end
        @(posedge clk); #1 in_src_rdy = 1'b0; out_dst_rdy = 1'b0;
    endtask

    task automatic test_saturate();
        @(posedge clk); #1;
        in_src_rdy = 1'b1; in_sof = 1'b1; in_eof = 1'b1; inport_addr = 4'd9;
        for (int i = 1; i <= 65537; i++) begin
            @(posedge clk); #1;
            if (exp_drop < 65535) exp_drop++;
            if (i == 65534 || i == 65535) begin
                n_tests++;
                if (drop_cnt !== 16'(exp_drop)) begin
                    $display("FAIL sat_count at %0d: got %h, want %h", i, drop_cnt, 16'(exp_drop));
                    n_fail++;
                end
            end
        end
        in_src_rdy = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        @(negedge clk);
        n_tests++;
        if (drop_cnt !== 16'hFFFF || drop_cnt_b !== 16'd0 || in_busy !== 1'b0) begin
            $display("FAIL sat_hold: got %h stall %h busy %b, want ffff 0000 0", drop_cnt, drop_cnt_b, in_busy);
            n_fail++;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_sof = 1'b0; in_eof = 1'b0; in_src_rdy = 1'b0; in_data = 8'h00;
        inport_addr = 4'd0; outport_addr = 4'd0; out_dst_rdy = 1'b0;
        ch_out_dst_rdy = 6'b111111; ch_in_sof = 6'd0; ch_in_eof = 6'd0; ch_in_src_rdy = 6'd0;
        ch_in_data = 48'd0;
        test_reset();
        test_addr_lock();
        test_drop_invalid();
        test_egress_lock();
        test_reframe();
        test_reset_midframe();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
